// File: rtl/fat32_chain_walker_if.sv
// Bus bundle between the FAT32 chain walker and its surroundings: SD block-read
// request path, FAT-table RAM read port, and the outgoing cluster stream.
interface fat32_chain_walker_if #(
    parameter int CLUS_W = 28
);
    logic              sd_rd_req;
    logic [31:0]       sd_rd_lba;
    logic              sd_rd_ack;
    logic              sd_rd_done;

    logic              fat_table_sel;
    logic              fat_table_rden;
    logic [8:0]        fat_table_rdaddress;
    logic [7:0]        fat_table_rddata;

    logic              clus_valid;
    logic              clus_ready;
    logic [CLUS_W-1:0] clus_out;
    logic              clus_last;

    modport master (
        output sd_rd_req, sd_rd_lba,
        input  sd_rd_ack, sd_rd_done,
        output fat_table_sel, fat_table_rden, fat_table_rdaddress,
        input  fat_table_rddata,
        output clus_valid, clus_out, clus_last,
        input  clus_ready
    );

    modport slave (
        input  sd_rd_req, sd_rd_lba,
        output sd_rd_ack, sd_rd_done,
        input  fat_table_sel, fat_table_rden, fat_table_rdaddress,
        output fat_table_rddata,
        input  clus_valid, clus_out, clus_last,
        output clus_ready
    );
endinterface

// File: rtl/fat32_chain_walker.sv
// Follows a FAT32 cluster chain: fetches FAT sectors through the SD read path
// (single-sector cache), reads 4-byte entries and streams the clusters out.
module fat32_chain_walker #(
    parameter int CLUS_W    = 28,
    parameter int MAX_CHAIN = 65536
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CLUS_W-1:0]    start_cluster,
    input  logic [31:0]          fat_begin_lba,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    fat32_chain_walker_if.master bus
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_REQ   = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_READ  = 3'd4;
    localparam logic [2:0] ST_EVAL  = 3'd5;
    localparam logic [2:0] ST_EMIT  = 3'd6;

    localparam int CNT_W = $clog2(MAX_CHAIN) + 1;
    localparam logic [CLUS_W-1:0] CLUS_MIN = CLUS_W'(2);
    localparam logic [CLUS_W-1:0] CLUS_BAD = CLUS_W'(28'h0FFF_FFF7);
    localparam logic [CLUS_W-1:0] CLUS_EOC = CLUS_W'(28'h0FFF_FFF8);

    logic [2:0]        state_q, state_d;
    logic [CLUS_W-1:0] cur_q, cur_d;
    logic [CLUS_W-1:0] nxt_q, nxt_d;
    logic [31:0]       fat_lba_q, fat_lba_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              cache_valid_q, cache_valid_d;
    logic [31:0]       cache_sector_q, cache_sector_d;
    logic [2:0]        rd_idx_q, rd_idx_d;
    logic [2:0][7:0]   blo_q, blo_d;
    logic [3:0]        b3_q, b3_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              req_q, req_d;
    logic [31:0]       lba_q, lba_d;
    logic              sel_q, sel_d;

    logic [31:0]       sector;
    logic [8:0]        offset;
    logic [CLUS_W-1:0] entry;
    logic [1:0]        cap_idx;
    logic [CNT_W-1:0]  cnt_inc;
    logic              rden;

    assign sector  = fat_lba_q + 32'(cur_q[CLUS_W-1:7]);
    assign offset  = {cur_q[6:0], 2'b00};
    assign entry   = CLUS_W'({b3_q, blo_q[2], blo_q[1], blo_q[0]});
    // rd_idx n>0 means the byte requested at n-1 is on rddata this cycle
    assign cap_idx = rd_idx_q[1:0] - 2'd1;
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign rden    = (state_q == ST_READ) && (rd_idx_q != 3'd4) && !sel_q;

    always_comb begin
        state_d        = state_q;
        cur_d          = cur_q;
        nxt_d          = nxt_q;
        fat_lba_d      = fat_lba_q;
        cnt_d          = cnt_q;
        last_d         = last_q;
        cache_valid_d  = cache_valid_q;
        cache_sector_d = cache_sector_q;
        rd_idx_d       = rd_idx_q;
        blo_d          = blo_q;
        b3_d           = b3_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        error_d        = 1'b0;
        req_d          = req_q;
        lba_d          = lba_q;
        sel_d          = sel_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (start_cluster < CLUS_MIN || start_cluster >= CLUS_BAD) begin
                        error_d = 1'b1;
                    end else begin
                        cur_d         = start_cluster;
                        fat_lba_d     = fat_begin_lba;
                        cnt_d         = '0;
                        cache_valid_d = 1'b0;
                        busy_d        = 1'b1;
                        state_d       = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (cache_valid_q && cache_sector_q == sector) begin
                    rd_idx_d = '0;
                    state_d  = ST_READ;
                end else begin
                    lba_d   = sector;
                    req_d   = 1'b1;
                    sel_d   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.sd_rd_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.sd_rd_done) begin
                    sel_d          = 1'b0;
                    cache_sector_d = lba_q;
                    cache_valid_d  = 1'b1;
                    rd_idx_d       = '0;
                    state_d        = ST_READ;
                end
            end
            ST_READ: begin
                rd_idx_d = rd_idx_q + 3'd1;
                if (rd_idx_q == 3'd4) begin
                    b3_d    = bus.fat_table_rddata[3:0];
                    state_d = ST_EVAL;
                end else if (rd_idx_q != 3'd0) begin
                    blo_d[cap_idx] = bus.fat_table_rddata;
                end
            end
            ST_EVAL: begin
                if (entry == CLUS_BAD || entry < CLUS_MIN) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    last_d  = (entry >= CLUS_EOC);
                    nxt_d   = entry;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (bus.clus_ready) begin
                    if (last_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else if (cnt_inc == CNT_W'(MAX_CHAIN)) begin
                        cnt_d   = cnt_inc;
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_inc;
                        cur_d   = nxt_q;
                        state_d = ST_CHECK;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cur_q          <= '0;
            nxt_q          <= '0;
            fat_lba_q      <= '0;
            cnt_q          <= '0;
            last_q         <= 1'b0;
            cache_valid_q  <= 1'b0;
            cache_sector_q <= '0;
            rd_idx_q       <= '0;
            blo_q          <= '0;
            b3_q           <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            req_q          <= 1'b0;
            lba_q          <= '0;
            sel_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_q          <= cur_d;
            nxt_q          <= nxt_d;
            fat_lba_q      <= fat_lba_d;
            cnt_q          <= cnt_d;
            last_q         <= last_d;
            cache_valid_q  <= cache_valid_d;
            cache_sector_q <= cache_sector_d;
            rd_idx_q       <= rd_idx_d;
            blo_q          <= blo_d;
            b3_q           <= b3_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
            req_q          <= req_d;
            lba_q          <= lba_d;
            sel_q          <= sel_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;

    assign bus.sd_rd_req           = req_q;
    assign bus.sd_rd_lba           = lba_q;
    assign bus.fat_table_sel       = sel_q;
    assign bus.fat_table_rden      = rden;
    assign bus.fat_table_rdaddress = rden ? (offset | 9'(rd_idx_q[1:0])) : 9'd0;
    assign bus.clus_valid          = (state_q == ST_EMIT);
    assign bus.clus_out            = cur_q;
    assign bus.clus_last           = (state_q == ST_EMIT) && last_q;
endmodule

// File: tb/tb_fat32_chain_walker.sv
// Directed bench for fat32_chain_walker: an SD/FAT-RAM responder, a chain-level
// reference model and a per-cycle compare process on the cluster stream.
`timescale 1ns/1ps
module tb_fat32_chain_walker;
    localparam int CW   = 28;
    localparam int MAXC = 4;

    typedef struct {
        logic [CW-1:0] c;
        logic          last;
    } clus_t;

    logic          sys_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] start_cluster = '0;
    logic [31:0]   fat_begin_lba = '0;
    logic          busy, done, error;

    fat32_chain_walker_if #(.CLUS_W(CW)) bus_if ();

    fat32_chain_walker #(.CLUS_W(CW), .MAX_CHAIN(MAXC)) dut (
        .sys_clk       (sys_clk),
        .rst_n         (rst_n),
        .start         (start),
        .start_cluster (start_cluster),
        .fat_begin_lba (fat_begin_lba),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .bus           (bus_if)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] fat [int unsigned];
    logic [7:0]  fat_ram [512];

    clus_t         exp_clus [$];
    logic [31:0]   exp_lba  [$];
    int            exp_outcome;
    logic [CW-1:0] obs_clus [$];
    logic [31:0]   obs_lba  [$];
    int            n_done = 0;
    int            n_err  = 0;
    logic [31:0]   walk_lba = '0;
    int            done_delay = 3;
    int            acked = 0;
    int            stall_left = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string why);
        total++;
        bad++;
        $display("FAIL %s: %s", name, why);
    endtask

    function automatic logic [31:0] get_fat(input int unsigned c);
        return fat.exists(c) ? fat[c] : 32'h0;
    endfunction

    // Chain-level model: which sectors get read, which clusters appear, how it ends.
    task automatic build_model(input logic [CW-1:0] sc, input logic [31:0] lba);
        logic [31:0] sec, prev;
        bit          have;
        int          n;
        int unsigned cur, e;
        exp_clus.delete();
        exp_lba.delete();
        have = 0;
        n    = 0;
        prev = 0;
        cur  = 32'(sc);
        if (sc < 2 || sc >= 28'h0FFF_FFF7) begin
            exp_outcome = 2;
            return;
        end
        forever begin
            sec = lba + (cur >> 7);
            if (!have || sec != prev) begin
                exp_lba.push_back(sec);
                prev = sec;
                have = 1;
            end
            e = get_fat(cur) & 32'h0FFF_FFFF;
            if (e == 32'h0FFF_FFF7 || e < 2) begin
                exp_outcome = 2;
                return;
            end
            exp_clus.push_back('{c: cur[CW-1:0], last: (e >= 32'h0FFF_FFF8)});
            n++;
            if (e >= 32'h0FFF_FFF8) begin
                exp_outcome = 1;
                return;
            end
            if (n == MAXC) begin
                exp_outcome = 2;
                return;
            end
            cur = e;
        end
    endtask

    // FAT-table RAM with registered read data
    always @(posedge sys_clk) begin
        if (bus_if.fat_table_rden === 1'b1)
            bus_if.fat_table_rddata <= fat_ram[bus_if.fat_table_rdaddress];
    end

    initial begin : sd_resp
        logic [31:0] lba;
        int unsigned base;
        logic [31:0] v;
        bus_if.sd_rd_ack  = 1'b0;
        bus_if.sd_rd_done = 1'b0;
        forever begin
            @(posedge sys_clk); #1;
            if (bus_if.sd_rd_req === 1'b1) begin
                repeat (2) @(posedge sys_clk);
                #1;
                lba = bus_if.sd_rd_lba;
                bus_if.sd_rd_ack = 1'b1;
                @(posedge sys_clk); #1;
                bus_if.sd_rd_ack = 1'b0;
                acked++;
                base = (lba - walk_lba) * 128;
                for (int j = 0; j < 128; j++) begin
                    v = get_fat(base + j);
                    for (int k = 0; k < 4; k++) fat_ram[4*j+k] = v[8*k +: 8];
                end
                repeat (done_delay) @(posedge sys_clk);
                #1;
                bus_if.sd_rd_done = 1'b1;
                @(posedge sys_clk); #1;
                bus_if.sd_rd_done = 1'b0;
            end
        end
    end

    initial begin : rdy_drv
        int cyc;
        cyc = 0;
        bus_if.clus_ready = 1'b0;
        forever begin
            @(posedge sys_clk); #1;
            cyc++;
            if (stall_left > 0 && bus_if.clus_valid === 1'b1) begin
                bus_if.clus_ready = 1'b0;
                stall_left--;
            end else begin
                bus_if.clus_ready = (cyc % 3 != 0);
            end
        end
    end

    // Compare process: cluster stream and read requests against the model every cycle
    initial begin : mon
        logic req_prev, hs_last_prev, sd_done_prev, sel_exp;
        req_prev = 0; hs_last_prev = 0; sd_done_prev = 0; sel_exp = 0;
        forever begin
            @(negedge sys_clk);
            if (rst_n !== 1'b1) begin
                req_prev = 0; hs_last_prev = 0; sd_done_prev = 0; sel_exp = 0;
                continue;
            end
            if (sd_done_prev) sel_exp = 0;
            if (bus_if.sd_rd_req && !req_prev) begin
                sel_exp = 1;
                obs_lba.push_back(bus_if.sd_rd_lba);
                if (exp_lba.size() == 0) fail_now("extra_read", $sformatf("got lba=0x%0h want none", bus_if.sd_rd_lba));
                else begin
                    check("read_lba", bus_if.sd_rd_lba, exp_lba[0]);
                    void'(exp_lba.pop_front());
                end
            end
            if (bus_if.sd_rd_req || sel_exp || bus_if.fat_table_sel)
                check("sel_window", bus_if.fat_table_sel, sel_exp);
            if (bus_if.fat_table_rden && bus_if.fat_table_sel)
                fail_now("rden_while_sel", "got rden=1 with sel=1 want rden=0");
            if (bus_if.clus_valid) begin
                if (exp_clus.size() == 0) fail_now("extra_cluster", $sformatf("got clus=0x%0h want none", bus_if.clus_out));
                else begin
                    check("clus_out", bus_if.clus_out, exp_clus[0].c);
                    check("clus_last", bus_if.clus_last, exp_clus[0].last);
                    if (bus_if.clus_ready) begin
                        obs_clus.push_back(bus_if.clus_out);
                        void'(exp_clus.pop_front());
                    end
                end
            end
            if (done) begin
                n_done++;
                check("done_after_last_hs", hs_last_prev, 1);
                check("busy_low_on_done", busy, 0);
            end
            if (error) begin
                n_err++;
                check("busy_low_on_error", busy, 0);
            end
            hs_last_prev = bus_if.clus_valid && bus_if.clus_ready && bus_if.clus_last;
            req_prev     = bus_if.sd_rd_req;
            sd_done_prev = bus_if.sd_rd_done;
        end
    end

    task automatic run_walk(input string tag, input logic [CW-1:0] sc, input logic [31:0] lba);
        bit start_ok;
        build_model(sc, lba);
        start_ok = !(sc < 2 || sc >= 28'h0FFF_FFF7);
        obs_clus.delete();
        obs_lba.delete();
        n_done   = 0;
        n_err    = 0;
        walk_lba = lba;
        @(posedge sys_clk); #1;
        start = 1'b1;
        start_cluster = sc;
        fat_begin_lba = lba;
        @(posedge sys_clk); #1;
        start = 1'b0;
        check({tag, "_busy_after_start"}, busy, start_ok);
        check({tag, "_err_after_start"}, error, !start_ok);
        for (int i = 0; i < 3000 && (n_done + n_err) == 0; i++) @(posedge sys_clk);
        repeat (4) @(posedge sys_clk);
        #1;
        if ((n_done + n_err) == 0) fail_now({tag, "_timeout"}, "got no done/error want one");
        check({tag, "_done_cnt"}, n_done, (exp_outcome == 1) ? 1 : 0);
        check({tag, "_err_cnt"}, n_err, (exp_outcome == 2) ? 1 : 0);
        check({tag, "_clus_left"}, exp_clus.size(), 0);
        check({tag, "_reads_left"}, exp_lba.size(), 0);
        $display("walk %s: start=0x%0h lba=0x%0h clusters=%0d reads=%0d done=%0d err=%0d",
                 tag, sc, lba, obs_clus.size(), obs_lba.size(), n_done, n_err);
    endtask

    task automatic stall_watch();
        logic [CW-1:0] so;
        logic          sl;
        for (int i = 0; i < 500 && bus_if.clus_valid !== 1'b1; i++) @(negedge sys_clk);
        if (bus_if.clus_valid !== 1'b1) begin
            fail_now("t10_stall_wait", "got no clus_valid want valid");
            return;
        end
        so = bus_if.clus_out;
        sl = bus_if.clus_last;
        check("t10_stall_first", so, 2);
        for (int k = 0; k < 19; k++) begin
            @(negedge sys_clk);
            if (k == 5) start = 1'b1;
            if (k == 6) start = 1'b0;
            check("t10_stall_valid", bus_if.clus_valid, 1);
            check("t10_stall_out", bus_if.clus_out, so);
            check("t10_stall_last", bus_if.clus_last, sl);
            check("t10_stall_rden", bus_if.fat_table_rden, 0);
            check("t10_stall_req", bus_if.sd_rd_req, 0);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500us");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int a0;
        fat[5]    = 32'h0FFF_FFF8;
        fat[2]    = 32'd3;
        fat[3]    = 32'd4;
        fat[4]    = 32'h0FFF_FFFF;
        fat[127]  = 32'd128;
        fat[128]  = 32'h0FFF_FFF8;
        fat[9]    = 32'd9;
        fat[32]   = 32'd33;
        fat[33]   = 32'h0FFF_FFF7;
        fat[48]   = 32'hF000_0031;
        fat[49]   = 32'hFFFF_FFF8;
        fat[64]   = 32'h0;

        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_req", bus_if.sd_rd_req, 0);
        check("rst_lba", bus_if.sd_rd_lba, 0);
        check("rst_sel", bus_if.fat_table_sel, 0);
        check("rst_rden", bus_if.fat_table_rden, 0);
        check("rst_valid", bus_if.clus_valid, 0);
        check("rst_clus_out", bus_if.clus_out, 0);
        check("rst_last", bus_if.clus_last, 0);
        rst_n = 1'b1;

        run_walk("t1", 28'd5, 32'h100);
        check("t1_nreads", obs_lba.size(), 1);
        if (obs_lba.size() > 0) check("t1_lba", obs_lba[0], 32'h100);
        check("t1_nclus", obs_clus.size(), 1);
        if (obs_clus.size() > 0) check("t1_clus", obs_clus[0], 5);

        run_walk("t2", 28'd2, 32'h100);
        check("t2_nreads", obs_lba.size(), 1);
        check("t2_nclus", obs_clus.size(), 3);
        if (obs_clus.size() == 3) begin
            check("t2_c0", obs_clus[0], 2);
            check("t2_c1", obs_clus[1], 3);
            check("t2_c2", obs_clus[2], 4);
        end

        run_walk("t3", 28'h7F, 32'h2000);
        check("t3_nreads", obs_lba.size(), 2);
        if (obs_lba.size() == 2) begin
            check("t3_lba0", obs_lba[0], 32'h2000);
            check("t3_lba1", obs_lba[1], 32'h2001);
        end

        run_walk("t4", 28'd0, 32'h100);
        check("t4_nreads", obs_lba.size(), 0);
        check("t4_nclus", obs_clus.size(), 0);

        run_walk("t5", 28'h20, 32'h100);
        check("t5_nclus", obs_clus.size(), 1);
        if (obs_clus.size() > 0) check("t5_clus", obs_clus[0], 28'h20);

        run_walk("t6", 28'h40, 32'h100);
        check("t6_nclus", obs_clus.size(), 0);

        run_walk("t7", 28'h30, 32'h100);
        check("t7_nclus", obs_clus.size(), 2);
        if (obs_clus.size() == 2) check("t7_c1", obs_clus[1], 28'h31);

        run_walk("t8", 28'h80, 32'hFFFF_FFFF);
        if (obs_lba.size() > 0) check("t8_wrap_lba", obs_lba[0], 32'h0);
        else fail_now("t8_wrap_lba", "got no read want one at lba 0");

        run_walk("t9", 28'd9, 32'h100);
        check("t9_nclus", obs_clus.size(), 4);
        check("t9_nreads", obs_lba.size(), 1);
        if (obs_clus.size() == 4) check("t9_c3", obs_clus[3], 9);

        run_walk("t11", 28'h0FFF_FFF7, 32'h100);
        check("t11_nreads", obs_lba.size(), 0);

        stall_left = 20;
        fork
            run_walk("t10", 28'd2, 32'h100);
            stall_watch();
        join
        check("t10_nclus", obs_clus.size(), 3);

        done_delay = 12;
        build_model(28'h7F, 32'h2000);
        obs_clus.delete();
        obs_lba.delete();
        walk_lba = 32'h2000;
        a0 = acked;
        @(posedge sys_clk); #1;
        start = 1'b1;
        start_cluster = 28'h7F;
        fat_begin_lba = 32'h2000;
        @(posedge sys_clk); #1;
        start = 1'b0;
        n_done = 0;
        n_err  = 0;
        for (int i = 0; i < 200 && acked == a0; i++) @(posedge sys_clk);
        check("t12_acked", acked - a0, 1);
        repeat (2) @(posedge sys_clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t12_rst_req", bus_if.sd_rd_req, 0);
        check("t12_rst_sel", bus_if.fat_table_sel, 0);
        check("t12_rst_busy", busy, 0);
        repeat (3) @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge sys_clk);
        #1;
        check("t12_no_done", n_done, 0);
        check("t12_no_err", n_err, 0);
        done_delay = 3;
        run_walk("t12b", 28'h7F, 32'h2000);
        check("t12b_nreads", obs_lba.size(), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fat32_chain_walker.md
Name: fat32_chain_walker

Overview:
- Sequences the shared SD block-read path and the FAT-table RAM to follow a FAT32 cluster chain.
- Given a start cluster, it fetches the FAT sectors it needs into the FAT-table RAM (by steering `fat_table_sel`) and reads the 4-byte entries.
- It streams each cluster number of the file, in order, to the file-data reader.
- It sits between the file/directory logic and the SD-read manager.

Parameters:
- CLUS_W, 28, cluster number width (FAT32).
- MAX_CHAIN, 65536, maximum clusters emitted before a loop-guard error.

Ports:
- sys_clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse that begins a walk. Ignored while busy=1.
- start_cluster  in  CLUS_W  first cluster of the file. Sampled on start.
- fat_begin_lba  in  32  LBA of FAT sector 0. Sampled on start.
- busy  out  1  high from the cycle after an accepted start until done/error.
- done  out  1  one-cycle pulse after the last cluster handshake.
- error  out  1  one-cycle pulse on invalid or free entry, bad cluster, or loop guard. busy drops in the same cycle.
- sd_rd_req  out  1  block-read request, held until sd_rd_ack.
- sd_rd_lba  out  32  LBA of the request. Stable while sd_rd_req=1.
- sd_rd_ack  in  1  request accepted.
- sd_rd_done  in  1  512-byte block fully written to RAM.
- fat_table_sel  out  1  routes SD output into the FAT-table RAM.
- fat_table_rden  out  1  FAT RAM read enable.
- fat_table_rdaddress  out  9  FAT RAM byte address.
- fat_table_rddata  in  8  FAT RAM data. Valid one cycle after rden (registered q).
- clus_valid  out  1  cluster output valid (valid/ready handshake).
- clus_ready  in  1  consumer ready.
- clus_out  out  CLUS_W  cluster number.
- clus_last  out  1  qualifies clus_out as the final cluster of the chain.

Behaviour:

Reset values:
- All outputs 0.
- Cache invalid, state IDLE.
- Reset mid-walk aborts immediately: sd_rd_req and fat_table_sel drop with reset, and no done/error is issued.

Address arithmetic (cur = current cluster):
- Sector = fat_begin_lba + {cur[CLUS_W-1:7]}, a 32-bit add that wraps silently.
- Byte offset = {cur[6:0], 2'b00}.

Cache:
- A sector register plus a valid bit.
- Invalidated on an accepted start.
- Set when sd_rd_done is seen for a read.
- A lookup whose sector equals the cached sector skips SD access.

States:
- IDLE: on start, latch inputs, cnt<=0, go to CHECK. If start_cluster<2 or >=0x0FFFFFF7, pulse error and stay in IDLE.
- CHECK: on cache hit go to READ. Otherwise sd_rd_lba<=sector, sd_rd_req<=1, fat_table_sel<=1, go to REQ.
- REQ: on sd_rd_ack, drop sd_rd_req and go to WAIT. fat_table_sel stays 1.
- WAIT: on sd_rd_done, fat_table_sel<=0, cache<=sector, go to READ. sd_rd_done outside WAIT is ignored.
- READ: issue four rden cycles at offset+0..+3. Capture bytes b0..b3 one cycle later each, so the entry is complete 5 cycles after READ entry.
  - entry = {b3[3:0], b2, b1, b0}.
  - fat_table_rden is only asserted while fat_table_sel=0.
- EVAL:
  - entry >= 0x0FFFFFF8: last=1.
  - entry == 0x0FFFFFF7, or entry < 2: error pulse, go to IDLE. Nothing is emitted for cur.
  - otherwise: last=0, nxt=entry.
  - Then go to EMIT.
- EMIT: clus_valid=1, clus_out=cur, clus_last=last. These hold until clus_ready.
  - On handshake with last=1: pulse done, go to IDLE.
  - On handshake with last=0: cnt+1. If cnt+1 == MAX_CHAIN, pulse error and go to IDLE. Otherwise cur<=nxt, go to CHECK.
- clus_valid may be held indefinitely. No other activity occurs while stalled.

Test Plan:
- fat_begin_lba=0x100, start_cluster=5, FAT sector 0x100 bytes 20..23 = F8 FF FF 0F -> one read at LBA 0x100; clus_out=5 with clus_last=1; done pulse; no error.
- start_cluster=2, entries 2->3, 3->4, 4->EOC, all in sector 0 -> exactly one sd_rd_req; clusters 2, 3, 4 emitted; clus_last only on 4.
- start_cluster=0x7F, entry 0x7F->0x80, 0x80->EOC -> two reads, LBAs fat_begin_lba+0 and +1; fat_table_sel high only from CHECK exit to sd_rd_done.
- start_cluster=0 -> error pulse the cycle after start; no sd_rd_req. Chain entry 0x0FFFFFF7 -> error, no cluster emitted for that step.
- clus_ready held low 20 cycles during EMIT -> clus_valid, clus_out, clus_last stable; no rden and no sd_rd_req during stall.
- Self-loop entry 9->9 with MAX_CHAIN=4 -> four clusters of 9 emitted, then error. Assert rst_n low during WAIT -> sd_rd_req=0, fat_table_sel=0, busy=0; next start re-reads (cache invalid).
